// File: rtl/mult_digit_sequencer_pkg.sv
// rtl/mult_digit_sequencer_pkg.sv - shared types and default constants for the online multiplier
package mult_pkg;

    // Defaults shared with the CA-register stage.
    localparam int UNROLLING_DEF    = 64;
    localparam int ONLINE_DELAY_DEF = 3;
    localparam int ADDR_WIDTH_DEF   = 7;
    localparam int IDX_WIDTH        = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

    // Radix-2 signed digit, {plus, minus}.
    typedef logic [1:0] digit_t;

    localparam digit_t DIGIT_ZERO = 2'b00;

    // Limit the operand length so that operand plus drain digits still fit the index.
    function automatic logic [IDX_WIDTH-1:0] clamp_digits(input logic [IDX_WIDTH-1:0] n,
                                                          input int                   od);
        logic [IDX_WIDTH-1:0] max_n;
        max_n = IDX_WIDTH'(2047 - od);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/mult_digit_sequencer_if.sv
// rtl/mult_digit_sequencer_if.sv - operand digit input handshake bundle
interface mult_digit_sequencer_if;

    mult_pkg::digit_t x_in;
    mult_pkg::digit_t y_in;
    logic             in_valid;
    logic             in_ready;

    // Upstream digit source drives the digits and valid.
    modport master (
        output x_in,
        output y_in,
        output in_valid,
        input  in_ready
    );

    // The sequencer consumes digits and returns ready.
    modport slave (
        input  x_in,
        input  y_in,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/mult_digit_sequencer_pos_counter.sv
// rtl/mult_digit_sequencer_pos_counter.sv - digit position within a word plus word address
module digit_pos_counter #(
    parameter int UNROLLING  = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int POS_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  advance_i,
    output logic [POS_WIDTH-1:0]  pos_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [POS_WIDTH-1:0]  pos_q, pos_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Next position: clear wins, otherwise step and roll into the next word at the wrap point.
    always_comb begin
        pos_d  = pos_q;
        addr_d = addr_q;
        if (clear_i) begin
            pos_d  = '0;
            addr_d = '0;
        end else if (advance_i) begin
            if (pos_q == POS_WIDTH'(UNROLLING - 1)) begin
                pos_d  = '0;
                addr_d = addr_q + ADDR_WIDTH'(1);
            end else begin
                pos_d  = pos_q + POS_WIDTH'(1);
            end
        end
    end

    // Position and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            addr_q <= '0;
        end else begin
            pos_q  <= pos_d;
            addr_q <= addr_d;
        end
    end

    assign pos_o  = pos_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/mult_digit_sequencer.sv
// rtl/mult_digit_sequencer.sv - digit re-timing and per-digit control for the CA-register stage
module mult_digit_sequencer
    import mult_pkg::*;
#(
    parameter int UNROLLING    = UNROLLING_DEF,
    parameter int ONLINE_DELAY = ONLINE_DELAY_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     asyn_reset_n,
    input  logic                     start,
    input  logic [10:0]              num_digits,
    mult_digit_sequencer_if.slave    digit_in,
    input  logic                     stall,
    output digit_t                   x_out,
    output digit_t                   y_out,
    output logic                     enable,
    output logic                     refresh,
    output logic [10:0]              counter,
    output logic [10:0]              shift_cnt,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0]  IDLE  = 2'(S_IDLE);
    localparam logic [1:0]  RUN   = 2'(S_RUN);
    localparam logic [1:0]  DRAIN = 2'(S_DRAIN);
    localparam logic [1:0]  DONE  = 2'(S_DONE);
    localparam logic [10:0] OD_W  = 11'(ONLINE_DELAY);

    logic [1:0]            state_q, state_d;
    logic [10:0]           idx_q, idx_d;
    logic [10:0]           num_q, num_d;

    digit_t                x_q, y_q;
    logic                  enable_q, refresh_q, done_q;
    logic [10:0]           counter_q, shift_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;

    logic                  start_acc;
    logic                  issue_run, issue_drain, issue;
    logic                  last_run, last_drain;
    logic                  rd_advance;
    digit_t                issue_x, issue_y;

    logic [10:0]           wr_pos;
    logic [ADDR_WIDTH-1:0] wr_addr_cur;
    logic [10:0]           unused_rd_pos;
    logic [ADDR_WIDTH-1:0] rd_addr_cur;

    assign start_acc   = (state_q == IDLE) && start;
    assign issue_run   = (state_q == RUN) && digit_in.in_valid && !stall;
    assign issue_drain = (state_q == DRAIN) && !stall;
    assign issue       = issue_run || issue_drain;
    assign last_run    = (idx_q == num_q - 11'd1);
    assign last_drain  = (idx_q == num_q + OD_W - 11'd1);

    // The read side trails the write side by the online delay, so it only starts moving then.
    assign rd_advance  = issue && (idx_q >= OD_W);

    assign issue_x     = issue_run ? digit_in.x_in : DIGIT_ZERO;
    assign issue_y     = issue_run ? digit_in.y_in : DIGIT_ZERO;

    assign digit_in.in_ready = (state_q == RUN) && !stall;

    digit_pos_counter #(
        .UNROLLING  (UNROLLING),
        .ADDR_WIDTH (ADDR_WIDTH),
        .POS_WIDTH  (11)
    ) u_wr_pos (
        .clk       (clk),
        .rst_n     (asyn_reset_n),
        .clear_i   (start_acc),
        .advance_i (issue),
        .pos_o     (wr_pos),
        .addr_o    (wr_addr_cur)
    );

    digit_pos_counter #(
        .UNROLLING  (UNROLLING),
        .ADDR_WIDTH (ADDR_WIDTH),
        .POS_WIDTH  (11)
    ) u_rd_pos (
        .clk       (clk),
        .rst_n     (asyn_reset_n),
        .clear_i   (start_acc),
        .advance_i (rd_advance),
        .pos_o     (unused_rd_pos),
        .addr_o    (rd_addr_cur)
    );

    // Pass sequencing: operand digits in RUN, zero flush digits in DRAIN, one DONE cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = clamp_digits(num_digits, ONLINE_DELAY);
                    idx_d   = '0;
                    state_d = (num_digits == 11'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue_run) begin
                    idx_d = idx_q + 11'd1;
                    if (last_run) begin
                        state_d = (ONLINE_DELAY == 0) ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (issue_drain) begin
                    idx_d = idx_q + 11'd1;
                    if (last_drain) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, issue index and latched pass length.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
        end
    end

    // Registered digit and control toward the CA-register stage; held while nothing issues.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            x_q       <= DIGIT_ZERO;
            y_q       <= DIGIT_ZERO;
            enable_q  <= 1'b0;
            refresh_q <= 1'b0;
            done_q    <= 1'b0;
            counter_q <= '0;
            shift_q   <= 11'(UNROLLING - 1);
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            enable_q  <= issue;
            refresh_q <= issue_run && (idx_q == 11'd0);
            done_q    <= (state_q == DONE);
            if (issue) begin
                x_q       <= issue_x;
                y_q       <= issue_y;
                counter_q <= wr_pos;
                shift_q   <= 11'(UNROLLING - 1) - wr_pos;
                wr_addr_q <= wr_addr_cur;
                rd_addr_q <= rd_addr_cur;
            end
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign enable    = enable_q;
    assign refresh   = refresh_q;
    assign counter   = counter_q;
    assign shift_cnt = shift_q;
    assign wr_addr   = wr_addr_q;
    assign rd_addr   = rd_addr_q;
    assign done      = done_q;

    // Busy covers the done pulse so it drops the cycle after done.
    assign busy      = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_mult_digit_sequencer.sv
// tb/tb_mult_digit_sequencer.sv - directed self-checking bench for mult_digit_sequencer
module tb_mult_digit_sequencer;

    logic        clk = 1'b0;
    logic        asyn_reset_n;
    logic        start;
    logic        stall;
    logic [10:0] num_digits;
    logic [1:0]  x_out, y_out;
    logic        enable, refresh, busy, done;
    logic [10:0] counter, shift_cnt;
    logic [6:0]  wr_addr, rd_addr;

    int errors = 0;
    int checks = 0;

    mult_digit_sequencer_if dif();

    mult_digit_sequencer dut (
        .clk          (clk),
        .asyn_reset_n (asyn_reset_n),
        .start        (start),
        .num_digits   (num_digits),
        .digit_in     (dif),
        .stall        (stall),
        .x_out        (x_out),
        .y_out        (y_out),
        .enable       (enable),
        .refresh      (refresh),
        .counter      (counter),
        .shift_cnt    (shift_cnt),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] dig(input int n);
        case (n % 3)
            0:       return 2'b10;
            1:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] exp_x(input int n, input int eff);
        return (n < eff) ? 32'(dig(n)) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_y(input int n, input int eff);
        return (n < eff) ? 32'(dig(n + 1)) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_rd(input int n);
        return (n < 3) ? 32'd0 : 32'(((n - 3) / 64) % 128);
    endfunction

    // One pass: digits in_valid whenever wanted, optional stalls at given issue counts,
    // optional abort (return without finishing) once abort_at digits have been issued.
    task automatic run_pass(input int num, input int abort_at, input int st_run_at,
                            input int st_drain_at, input bit hold_start);
        int eff, total, n, guard, left_r, left_d;
        logic st;
        eff   = (num > 2044) ? 2044 : num;
        total = (eff == 0) ? 0 : eff + 3;
        start = 1'b1;
        num_digits = 11'(num);
        dif.in_valid = 1'b0;
        stall = 1'b0;
        step();
        start = hold_start;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("enable_after_start", 32'(enable), 32'd0);
        chk("in_ready_after_start", 32'(dif.in_ready), 32'(total > 0));
        n = 0;
        guard = 0;
        left_r = 4;
        left_d = 2;
        while (n < total && guard < total + 50) begin
            st = 1'b0;
            if (n == st_run_at && left_r > 0) begin st = 1'b1; left_r--; end
            if (n == st_drain_at && left_d > 0) begin st = 1'b1; left_d--; end
            stall = st;
            dif.in_valid = (n < eff);
            dif.x_in = dig(n);
            dif.y_in = dig(n + 1);
            step();
            chk("enable", 32'(enable), 32'(!st));
            chk("done_low_in_pass", 32'(done), 32'd0);
            if (enable === 1'b1) begin
                chk("x_out", 32'(x_out), exp_x(n, eff));
                chk("y_out", 32'(y_out), exp_y(n, eff));
                chk("refresh", 32'(refresh), 32'(n == 0));
                chk("counter", 32'(counter), 32'(n % 64));
                chk("shift_cnt", 32'(shift_cnt), 32'(63 - (n % 64)));
                chk("wr_addr", 32'(wr_addr), 32'((n / 64) % 128));
                chk("rd_addr", 32'(rd_addr), exp_rd(n));
                n++;
            end else if (n > 0) begin
                chk("hold_refresh", 32'(refresh), 32'd0);
                chk("hold_counter", 32'(counter), 32'((n - 1) % 64));
                chk("hold_wr_addr", 32'(wr_addr), 32'(((n - 1) / 64) % 128));
                chk("hold_x_out", 32'(x_out), exp_x(n - 1, eff));
            end
            guard++;
            if (abort_at >= 0 && n == abort_at) return;
        end
        start = 1'b0;
        stall = 1'b0;
        dif.in_valid = 1'b0;
        chk("issued_count", 32'(n), 32'(total));
        step();
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_with_done", 32'(busy), 32'd1);
        chk("enable_after_pass", 32'(enable), 32'd0);
        step();
        chk("done_falls", 32'(done), 32'd0);
        chk("busy_falls", 32'(busy), 32'd0);
        chk("in_ready_idle", 32'(dif.in_ready), 32'd0);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_enable"}, 32'(enable), 32'd0);
        chk({pfx, "_refresh"}, 32'(refresh), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_x_out"}, 32'(x_out), 32'd0);
        chk({pfx, "_y_out"}, 32'(y_out), 32'd0);
        chk({pfx, "_counter"}, 32'(counter), 32'd0);
        chk({pfx, "_shift_cnt"}, 32'(shift_cnt), 32'd63);
        chk({pfx, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({pfx, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({pfx, "_in_ready"}, 32'(dif.in_ready), 32'd0);
    endtask

    initial begin
        asyn_reset_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        num_digits = 11'd0;
        dif.in_valid = 1'b0;
        dif.x_in = 2'b00;
        dif.y_in = 2'b00;
        repeat (3) step();
        asyn_reset_n = 1'b1;
        step();
        chk_reset_values("reset");

        // Digits offered outside RUN are ignored.
        dif.in_valid = 1'b1;
        dif.x_in = 2'b10;
        step();
        step();
        chk("idle_valid_enable", 32'(enable), 32'd0);
        chk("idle_valid_x_out", 32'(x_out), 32'd0);
        dif.in_valid = 1'b0;

        // Short pass: 5 digits plus 3 drain digits.
        run_pass(5, -1, -1, -1, 1'b0);

        // Word boundary wraps on both write and read addresses.
        run_pass(130, -1, -1, -1, 1'b0);

        // Stalls mid-RUN and in DRAIN, with start held high (must be ignored while busy).
        run_pass(20, -1, 10, 21, 1'b1);

        // Zero-length pass: no digits, done two cycles after start.
        run_pass(0, -1, -1, -1, 1'b0);

        // Over-long request is clamped to 2044 operand digits.
        run_pass(2047, -1, -1, -1, 1'b0);

        // Reset in the middle of a pass, after 40 issued digits.
        run_pass(100, 40, -1, -1, 1'b0);
        #2;
        asyn_reset_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        start = 1'b0;
        stall = 1'b0;
        dif.in_valid = 1'b0;
        @(negedge clk);
        asyn_reset_n = 1'b1;
        step();
        step();
        chk("no_done_after_reset", 32'(done), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // Fresh pass after reset starts at counter 0 / wr_addr 0 with refresh.
        run_pass(5, -1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
